// File: rtl/uart_rx_pkg.sv
// Purpose : shared constants and the RX status-flag bundle for the UART receive path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   UART_DATA_WIDTH     - width of one deserialized word
//   UART_RX_FIFO_DEPTH  - default receive buffer depth
//   uart_rx_status_t    - {empty, full, almost_full, overrun}, also consumed by the status register block
package uart_rx_pkg;

    localparam int UART_DATA_WIDTH    = 8;
    localparam int UART_RX_FIFO_DEPTH = 8;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_full;
        logic overrun;
    } uart_rx_status_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Purpose : DEPTH x DATA_WIDTH storage array, synchronous write, asynchronous read.
// Latency : write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none; the caller decides when a write is legal.
//
// Ports:
//   CLK, RST  - clock, asynchronous active-high reset (clears every entry)
//   i_we      - write enable
//   i_waddr   - write address
//   i_wdata   - write data
//   i_raddr   - read address
//   o_rdata   - read data, mem[i_raddr]
module uart_rx_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0]    o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Entries are cleared on reset so an empty buffer presents 0 on the read port.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose : circular receive buffer between the UART RX controller and the host, with sticky overrun.
// Latency : push visible on count/flags next cycle; first-word-fall-through read, pop consumes the presented word.
// Backpressure: none toward the RX controller; a push into a full buffer (without a same-cycle pop) is dropped and flagged.
//
// Ports:
//   CLK, RST     - clock, asynchronous active-high reset
//   P_DATA       - deserialized word, sampled when data_valid=1
//   data_valid   - one-cycle push strobe
//   rd_en        - host pop strobe (ignored while empty)
//   clr_ovr      - clears overrun (a same-cycle overrun event wins)
//   rd_data      - head-of-buffer word
//   empty/full/almost_full - decoded from count
//   count        - occupancy 0..DEPTH
//   overrun      - sticky dropped-word flag
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = UART_RX_FIFO_DEPTH,
    parameter int AF_LEVEL   = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   data_valid,
    input  logic                   rd_en,
    input  logic                   clr_ovr,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);

    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_overrun;

    logic            w_push;
    logic            w_pop;
    logic            w_ovr_set;
    uart_rx_status_t w_status;

    // Flags decode only from registered state, so no input reaches an output combinationally.
    always_comb begin
        w_status             = '0;
        w_status.empty       = (r_count == '0);
        w_status.full        = (r_count == C_DEPTH);
        w_status.almost_full = (r_count >= C_AF);
        w_status.overrun     = r_overrun;
    end

    // A pop frees a slot in the same cycle, so a push into a full buffer is accepted alongside it.
    assign w_pop     = rd_en & ~w_status.empty;
    assign w_push    = data_valid & (~w_status.full | w_pop);
    assign w_ovr_set = data_valid & w_status.full & ~w_pop;

    uart_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .CLK     (CLK),
        .RST     (RST),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (P_DATA),
        .i_raddr (r_rd_ptr),
        .o_rdata (rd_data)
    );

    // Pointers wrap by natural overflow since DEPTH is a power of two.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Set has priority over clear so an overrun in the clearing cycle is not lost.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end else if (clr_ovr) begin
            r_overrun <= 1'b0;
        end
    end

    assign empty       = w_status.empty;
    assign full        = w_status.full;
    assign almost_full = w_status.almost_full;
    assign overrun     = w_status.overrun;
    assign count       = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AF    = 6;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [DW-1:0] P_DATA = '0;
    logic          data_valid = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_ovr = 1'b0;
    logic [DW-1:0] rd_data;
    logic          empty;
    logic          full;
    logic          almost_full;
    logic [3:0]    count;
    logic          overrun;

    uart_rx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .P_DATA      (P_DATA),
        .data_valid  (data_valid),
        .rd_en       (rd_en),
        .clr_ovr     (clr_ovr),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overrun     (overrun)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer contents as a plain queue plus the sticky flag.
    logic [DW-1:0] mq[$];
    logic          m_ovr;

    typedef struct {
        logic          dv;
        logic [DW-1:0] d;
        logic          rd;
        logic          clr;
        int            e_cnt;
        logic          e_empty;
        logic          e_full;
        logic          e_af;
        logic          e_ovr;
        logic [DW-1:0] e_rd;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"},  {28'd0, count}, n);
        chk({tag, ".empty"},  {31'd0, empty}, (n == 0) ? 1 : 0);
        chk({tag, ".full"},   {31'd0, full}, (n == DEPTH) ? 1 : 0);
        chk({tag, ".af"},     {31'd0, almost_full}, (n >= AF) ? 1 : 0);
        chk({tag, ".ovr"},    {31'd0, overrun}, {31'd0, m_ovr});
        if (n > 0) chk({tag, ".rd_data"}, {24'd0, rd_data}, {24'd0, mq[0]});
    endtask

    // One clock with the given inputs; the model advances at the edge from pre-edge state.
    task automatic step(input logic dv, input logic [DW-1:0] d, input logic rd, input logic clr,
                        input string tag);
        logic pop, was_full, push;
        data_valid = dv; P_DATA = d; rd_en = rd; clr_ovr = clr;
        @(posedge CLK);
        pop      = rd && (mq.size() > 0);
        was_full = (mq.size() == DEPTH);
        push     = dv && (!was_full || pop);
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(d);
        if (dv && was_full && !pop) m_ovr = 1'b1;
        else if (clr)               m_ovr = 1'b0;
        #1;
        data_valid = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
        compare_model(tag);
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        model_reset();
        #1;
        chk("rst.rd_data", {24'd0, rd_data}, 0);
        compare_model("rst");
        @(posedge CLK);
        #1;
        RST = 1'b0;
        compare_model("rst_rel");
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5] = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

        model_reset();
        RST = 1'b1;
        #12;
        chk("por.rd_data", {24'd0, rd_data}, 0);
        compare_model("por");
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Basic push/pop and empty-boundary vectors.
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].dv, tbl[i].d, tbl[i].rd, tbl[i].clr, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.cnt", i),   {28'd0, count}, tbl[i].e_cnt);
            chk($sformatf("tbl%0d.empty", i), {31'd0, empty}, {31'd0, tbl[i].e_empty});
            chk($sformatf("tbl%0d.full", i),  {31'd0, full},  {31'd0, tbl[i].e_full});
            chk($sformatf("tbl%0d.af", i),    {31'd0, almost_full}, {31'd0, tbl[i].e_af});
            chk($sformatf("tbl%0d.ovr", i),   {31'd0, overrun}, {31'd0, tbl[i].e_ovr});
            if (!tbl[i].e_empty)
                chk($sformatf("tbl%0d.rd", i), {24'd0, rd_data}, {24'd0, tbl[i].e_rd});
        end

        // Fill, almost_full threshold, overrun on a dropped word, in-order drain.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0, "fill");
            chk("fill.af_thr", {31'd0, almost_full}, (i + 1 >= 6) ? 1 : 0);
        end
        chk("fill.count8", {28'd0, count}, 8);
        chk("fill.full",   {31'd0, full}, 1);
        step(1'b1, 8'hFF, 1'b0, 1'b0, "drop");
        chk("drop.ovr",   {31'd0, overrun}, 1);
        chk("drop.count", {28'd0, count}, 8);
        for (int i = 0; i < 8; i++) begin
            chk("drain.order", {24'd0, rd_data}, i);
            step(1'b0, 8'h00, 1'b1, 1'b0, "drain");
        end
        chk("drain.empty", {31'd0, empty}, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "clr");
        chk("clr.ovr", {31'd0, overrun}, 0);

        // Full with simultaneous pop and push.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "refill");
        step(1'b1, 8'h99, 1'b1, 1'b0, "fullrw");
        chk("fullrw.count", {28'd0, count}, 8);
        chk("fullrw.ovr",   {31'd0, overrun}, 0);
        for (int i = 1; i < 8; i++) begin
            chk("fullrw.order", {24'd0, rd_data}, i);
            step(1'b0, 8'h00, 1'b1, 1'b0, "fullrw_drain");
        end
        chk("fullrw.last", {24'd0, rd_data}, 32'h99);
        step(1'b0, 8'h00, 1'b1, 1'b0, "fullrw_last");

        // Wrap-around with interleaved push/pop.
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'h40 + i), 1'b1, 1'b0, "wrap");
            chk("wrap.data", {24'd0, rd_data}, 32'h40 + i);
            chk("wrap.cnt_le2", (count <= 4'd2) ? 32'd1 : 32'd0, 1);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0, "wrap_end");

        // Overrun and clear in the same cycle: set wins.
        for (int i = 0; i < 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0, "fill2");
        step(1'b1, 8'hEE, 1'b0, 1'b1, "setclr");
        chk("setclr.ovr", {31'd0, overrun}, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1, "clronly");
        chk("clronly.ovr", {31'd0, overrun}, 0);

        // Asynchronous reset mid-burst at count 5.
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, "burst");
        chk("burst.count5", {28'd0, count}, 5);
        data_valid = 1'b1; P_DATA = 8'h55;
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        chk("async.count",   {28'd0, count}, 0);
        chk("async.empty",   {31'd0, empty}, 1);
        chk("async.rd_data", {24'd0, rd_data}, 0);
        compare_model("async");
        @(posedge CLK);
        #1;
        data_valid = 1'b0;
        RST = 1'b0;
        compare_model("async_rel");
        step(1'b0, 8'h00, 1'b1, 1'b0, "rd_empty");
        chk("rd_empty.count", {28'd0, count}, 0);
        chk("rd_empty.ovr",   {31'd0, overrun}, 0);

        // Randomized traffic against the model, alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 250; c++) begin
                logic dv, rd, clr;
                dv  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 35));
                rd  = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 70));
                clr = ($urandom_range(0, 99) < 8);
                step(dv, 8'($urandom_range(0, 255)), rd, clr, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART RX controller and deserializer. Each `data_valid` pulse from the RX controller pushes the current parallel word `P_DATA` into a small circular buffer. The host side pops words with a single-cycle read strobe. The block decouples frame arrival from host read latency and reports when bytes were dropped because the buffer was full.

## Interface
- `DATA_WIDTH`, default 8: width of one received word; must match the deserializer output.
- `DEPTH`, default 8: number of storage entries; a power of two, at least 2.
- `AF_LEVEL`, default 6: occupancy at or above which `almost_full` asserts; range 1..DEPTH.

Ports (name, direction, width, meaning):
- `CLK`  in  1: single clock; the block has one clock domain, shared with the RX controller.
- `RST`  in  1: asynchronous, active-high reset.
- `P_DATA`  in  DATA_WIDTH: parallel word from the deserializer, sampled only when `data_valid`=1.
- `data_valid`  in  1: one-cycle push strobe from the RX controller, asserted only for frames with no stop/parity error.
- `rd_en`  in  1: pop strobe from the host.
- `clr_ovr`  in  1: clears the sticky `overrun` flag.
- `rd_data`  out  DATA_WIDTH: head-of-buffer word (first-word-fall-through); valid while `empty`=0.
- `empty`  out  1: occupancy is 0.
- `full`  out  1: occupancy equals DEPTH.
- `almost_full`  out  1: occupancy ≥ AF_LEVEL.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overrun`  out  1: sticky flag; a push arrived while the buffer was full.

## Operation
- Storage: DEPTH×DATA_WIDTH array.
- Pointers: `wr_ptr` and `rd_ptr`, each $clog2(DEPTH) bits, wrapping modulo DEPTH with natural overflow.
- `count` is a registered occupancy counter. `empty`, `full` and `almost_full` decode combinationally from `count`.
- Effective push: `push = data_valid & (~full | pop)`.
- Effective pop: `pop = rd_en & ~empty`.
- Push: write `P_DATA` to `mem[wr_ptr]`, then increment `wr_ptr`.
- Pop: increment `rd_ptr`.
- Count update:
  - push and pop together: `count` unchanged.
  - push only: `count`+1.
  - pop only: `count`−1.
- `rd_data = mem[rd_ptr]`, read combinationally from registered storage.
- Overrun:
  - `data_valid`=1 while `full`=1 and no pop: the word is dropped, storage and pointers are unchanged, and `overrun` is set to 1.
  - `overrun` stays at 1 until a cycle with `clr_ovr`=1.
  - If set and clear coincide, set wins.
- Boundary cases:
  - Full with simultaneous `rd_en` and `data_valid`: both are accepted, `count` stays at DEPTH, and no overrun is flagged.
  - Empty with simultaneous `rd_en` and `data_valid`: only the push occurs. The pop is ignored because `empty`=1 that cycle.
  - `rd_en` while empty: no state change and no error flag.
- Reset (asynchronous, at any time including mid-frame or mid-burst):
  - `wr_ptr`, `rd_ptr`, `count` and `overrun` go to 0.
  - All storage entries go to 0.
  - Output reset values: `rd_data`=0, `empty`=1, `full`=0, `almost_full`=0 (AF_LEVEL ≥ 1), `count`=0, `overrun`=0.
  - Any word pushed in the reset cycle is lost.

## Timing
- All state updates on the rising edge of `CLK`.
- `RST` takes effect immediately and asynchronously. Release is synchronous to the next edge.
- Push latency:
  - `data_valid` high in cycle N: `count`, `empty` and `full` update after the edge ending cycle N.
  - The word appears on `rd_data` in cycle N+1 if the buffer was empty.
- Pop latency: `rd_en` in cycle N with `empty`=0 means the word on `rd_data` in cycle N is consumed. The next word, or 0/stale data with `empty`=1, is presented in cycle N+1.
- Overrun: `overrun` rises in the cycle after the dropped push.
- Throughput: one push and one pop per cycle sustained. `data_valid` arrives at most once per frame, so only the host side limits throughput.
- No combinational path from `data_valid` or `P_DATA` to any output.

## Structure
- Shared package `uart_rx_pkg`:
  - `UART_DATA_WIDTH` = 8.
  - `UART_RX_FIFO_DEPTH` = 8.
  - The status-flag bundle typedef (`empty`, `full`, `almost_full`, `overrun`), for reuse by the status register block.
- Optional sub-module `uart_rx_fifo_mem`: storage array with a synchronous write port and an asynchronous read port.
- Pointer, count and flag logic stays in `uart_rx_fifo`.

## Test plan
- Reset, then push 0xA5, 0x3C: `empty` falls one cycle after the first push, `rd_data`=0xA5 and `count`=2. Pop once: `rd_data`=0x3C and `count`=1.
- Push 8 words 0x00..0x07 (DEPTH=8): `full`=1, `almost_full`=1 from count 6, `count`=8. Push 0xFF: `overrun`=1, 0xFF is never read, and pops return 0x00..0x07 in order.
- Full buffer with `rd_en`=1 and `data_valid`=1 (P_DATA=0x99) in the same cycle: `count` stays 8, `overrun` stays 0, and 0x99 is the last word read.
- Wrap-around: 20 interleaved push/pop pairs with an incrementing pattern return data in order. `count` never exceeds 2 and `empty`/`full` decode correctly across pointer wrap.
- `clr_ovr` and an overrun event in the same cycle: `overrun` stays at 1. `clr_ovr` alone next cycle clears it.
- Assert `RST` asynchronously mid-burst with `count`=5: all outputs take reset values before the next edge. `rd_en` while empty leaves `count`=0 with no flag change.
